fifo_stream_reader: RTL and testbench

Read-side companion to the team's synchronous register FIFO. It drains the FIFO through its `ren`/`empty`/`dout` port, which has a one-cycle read latency, and presents the words downstream as a registered valid/ready stream. A 3-entry prefetch buffer sustains one word per cycle without any combinational path from `m_ready` to `fifo_ren`. It sits between the FIFO instance and the consuming datapath stage; the paired FIFO is built with `wfirst` tied low.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_stream_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the register FIFO and its stream reader.
//   PREFETCH_DEPTH : number of read-ahead slots in fifo_stream_reader
//   rd_idx_t       : 2-bit type for head/tail pointers and occupancy
//   idx_inc        : advance a pointer through 0..PREFETCH_DEPTH-1 with wrap
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int PREFETCH_DEPTH = 3;

    typedef logic [1:0] rd_idx_t;

    // Pointers run 0,1,2,0,... ; value 3 is never reached.
    function automatic rd_idx_t idx_inc(input rd_idx_t i);
        return (i == rd_idx_t'(PREFETCH_DEPTH - 1)) ? '0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Drains a synchronous register FIFO (one-cycle read latency) and presents
// its words as a registered valid/ready stream, using a 3-entry prefetch
// buffer so one word per cycle is sustained with no combinational path from
// m_ready to fifo_ren.
//
// Handshake: a stream word transfers in every cycle where m_valid && m_ready
// are both high at the rising edge; once m_valid is high, m_valid and m_data
// hold until that transfer unless flush or rst intervenes.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : discard all buffered and in-flight words this cycle
//   fifo_ren        : read request to the FIFO
//   fifo_empty      : FIFO empty flag
//   fifo_dout[W]    : FIFO read data, valid the cycle after an accepted read
//   m_valid/m_ready : stream handshake
//   m_data[W]       : stream word
//   rd_cnt[CNT_W]   : handshake counter (only with FIFO_READER_STATS_EN)
//
// Build option: define FIFO_READER_STATS_EN to add the rd_cnt port and
// counter. rd_cnt clears on rst only and wraps modulo 2^CNT_W.
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int W     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             fifo_ren,
    input  logic             fifo_empty,
    input  logic [W-1:0]     fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [CNT_W-1:0] rd_cnt
`endif
);

    if (W < 1 || CNT_W < 1) begin : g_bad_width
        $error("fifo_stream_reader: W and CNT_W must be at least 1");
    end

    logic [W-1:0] buf_q [PREFETCH_DEPTH];
    logic [W-1:0] buf_d [PREFETCH_DEPTH];
    rd_idx_t      head_q, head_d;
    rd_idx_t      tail_q, tail_d;
    rd_idx_t      cnt_q, cnt_d;
    logic         pend_q, pend_d;

    logic         pop;
    logic         land;
    logic [2:0]   credit_used;

    // Slots already spoken for: words held plus the word still in flight.
    // Issuing only while this is below the depth means a landing word always
    // finds a free slot, even if downstream stalls indefinitely.
    assign credit_used = {1'b0, cnt_q} + {2'b0, pend_q};
    assign fifo_ren    = !rst && !flush && !fifo_empty
                         && (credit_used < 3'(PREFETCH_DEPTH));

    assign m_valid = (cnt_q != '0);
    assign m_data  = buf_q[head_q];
    assign pop     = m_valid && m_ready;
    // A word arriving during a flush cycle is dropped.
    assign land    = pend_q && !flush;

    always_comb begin
        buf_d  = buf_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        pend_d = fifo_ren && !fifo_empty;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (land) begin
                buf_d[tail_q] = fifo_dout;
                tail_d        = idx_inc(tail_q);
            end
            if (pop) begin
                head_d = idx_inc(head_q);
            end
            cnt_d = cnt_q + rd_idx_t'(land) - rd_idx_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    // A landing word with all slots full and nothing leaving would overwrite
    // the head; the credit rule must make this unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(land && (cnt_q == rd_idx_t'(PREFETCH_DEPTH)) && !pop));
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    // Counts every handshake, including one that coincides with flush.
    always_comb begin
        rd_cnt_d = rd_cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Bench for fifo_stream_reader paired with a behavioural register FIFO
// (one-cycle read latency, write does not bypass to a same-cycle read).
// Build option FIFO_READER_STATS_EN enables the rd_cnt checks.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int W     = 3;
    localparam int CNT_W = 16;

    // ---------------- clock / reset / DUT ----------------
    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         flush      = 1'b0;
    logic         fifo_ren;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout  = '0;
    logic         m_valid;
    logic         m_ready    = 1'b0;
    logic [W-1:0] m_data;
    logic         wr_en      = 1'b0;
    logic [W-1:0] wr_data    = '0;
`ifdef FIFO_READER_STATS_EN
    logic [CNT_W-1:0] rd_cnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_ren   (fifo_ren),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_READER_STATS_EN
        ,
        .rd_cnt     (rd_cnt)
`endif
    );

    // ---------------- behavioural FIFO (same rst domain) ----------------
    logic [W-1:0] fifo_q [$];

    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_dout  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_ren && !fifo_empty) fifo_dout <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(wr_data);
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // ---------------- scoreboard ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q [$];
    logic         sb_on     = 1'b0;
    int           acc_reads = 0;
    int           handshakes = 0;
    logic         hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference view: words leave in write order, each exactly once; a
    // presented word is held while stalled; never more than 3 words read
    // ahead of the consumer; no read request against an empty FIFO.
    task automatic sb_step();
        if (sb_on) begin
            if (fifo_ren) check("ren_while_empty", fifo_empty, 0);
            check("read_ahead_le3", (acc_reads - handshakes) <= 3, 1);
            if (hold_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) fail_now("spurious_word", int'(m_data), -1);
                else check("stream_order", m_data, exp_q.pop_front());
                handshakes++;
            end
            if (fifo_ren && !fifo_empty) acc_reads++;
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled on
    // the falling edge of the same cycle.
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic rdy,
                         input logic fl, input logic r);
        @(posedge clk);
        #1;
        wr_en   = w;
        wr_data = d;
        m_ready = rdy;
        flush   = fl;
        rst     = r;
        if (w && !r) exp_q.push_back(d);
        @(negedge clk);
        sb_step();
    endtask

    task automatic do_reset();
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        exp_q.delete();
        acc_reads  = 0;
        handshakes = 0;
        hold_prev  = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_fifo_ren", fifo_ren, 0);
        check("rst_m_data", m_data, 0);
`ifdef FIFO_READER_STATS_EN
        check("rst_rd_cnt", rd_cnt, 0);
`endif
    endtask

    // Load words while flush blocks reading, so the reader starts from a full
    // FIFO in a known cycle.
    task automatic preload(input int n, input int first);
        for (int i = 0; i < n; i++) cycle(1, W'(first + i), 0, 1, 0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < budget) begin
            cycle(0, '0, 1, 0, 0);
            k++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", m_valid, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         w;
        logic [W-1:0] d;
        logic         rdy;
        logic         fl;
        logic         e_ren;
        logic         e_valid;
        logic [W-1:0] e_data;
    } vec_t;

    vec_t tv [$];

    initial begin : timeout
        #200000;
        $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
        $fatal(1);
    end

    initial begin : main
        int pulses;
        vec_t v;

        // ---- table: idle/empty, then 1..7,0 at full rate ----
        for (int i = 0; i < 6; i++) begin          // FIFO empty throughout
            v = '{w:0, d:'0, rdy:1, fl:0, e_ren:0, e_valid:0, e_data:'0};
            tv.push_back(v);
        end
        for (int k = 1; k <= 8; k++) begin         // preload under flush
            v = '{w:1, d:W'(k % 8), rdy:1, fl:1, e_ren:0, e_valid:0, e_data:'0};
            tv.push_back(v);
        end
        for (int c = 0; c < 12; c++) begin         // release, m_ready high
            v = '{w:0, d:'0, rdy:1, fl:0, e_ren:(c < 8), e_valid:(c >= 2 && c <= 9),
                  e_data:W'((c - 1) % 8)};
            tv.push_back(v);
        end

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            cycle(tv[i].w, tv[i].d, tv[i].rdy, tv[i].fl, 0);
            check($sformatf("tv%0d_ren", i), fifo_ren, tv[i].e_ren);
            check($sformatf("tv%0d_valid", i), m_valid, tv[i].e_valid);
            if (tv[i].e_valid) check($sformatf("tv%0d_data", i), m_data, tv[i].e_data);
        end
`ifdef FIFO_READER_STATS_EN
        check("tv_rd_cnt", rd_cnt, 8);
`endif

        // ---- back-pressure: 6 words, m_ready low for 10 cycles ----
        do_reset();
        preload(6, 1);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(0, '0, 0, 0, 0);
            if (fifo_ren) pulses++;
            if (c >= 2) begin
                check("bp_valid", m_valid, 1);
                check("bp_data_stable", m_data, 1);
            end
        end
        check("bp_ren_pulses", pulses, 3);
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, 1, 0, 0);
            check("bp_drain_valid", m_valid, 1);
            check("bp_drain_data", m_data, i + 1);
        end
        cycle(0, '0, 1, 0, 0);
        check("bp_after_drain", m_valid, 0);

        // ---- flush the cycle after a read ----
        do_reset();
        preload(4, 1);
        cycle(0, '0, 1, 0, 0);
        check("fl_ren_c0", fifo_ren, 1);
        cycle(0, '0, 1, 1, 0);
        check("fl_ren_low", fifo_ren, 0);
        cycle(0, '0, 1, 0, 0);
        check("fl_valid_c2", m_valid, 0);
        check("fl_ren_c2", fifo_ren, 1);
        cycle(0, '0, 1, 0, 0);
        check("fl_valid_c3", m_valid, 0);
        cycle(0, '0, 1, 0, 0);
        check("fl_valid_c4", m_valid, 1);
        check("fl_next_word", m_data, 2);

        // ---- reset with two words held and one in flight ----
        do_reset();
        preload(6, 1);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        check("rs_first", m_data, 1);
        cycle(0, '0, 0, 0, 0);
`ifdef FIFO_READER_STATS_EN
        check("rs_rd_cnt_pre", rd_cnt, 1);
`endif
        check("rs_ren_c3", fifo_ren, 1);
        cycle(0, '0, 0, 0, 1);                     // rst during cnt=2, pend=1
        check("rs_ren_in_rst", fifo_ren, 0);
        cycle(0, '0, 0, 0, 0);
        check("rs_valid", m_valid, 0);
        check("rs_ren", fifo_ren, 0);
        check("rs_data", m_data, 0);
`ifdef FIFO_READER_STATS_EN
        check("rs_rd_cnt", rd_cnt, 0);
`endif

        // ---- m_ready 1,0,1,0 with continuous supply ----
        do_reset();
        sb_on = 1'b1;
        for (int c = 0; c < 40; c++) cycle(1, W'($urandom_range(0, 7)), (c % 2) == 0, 0, 0);
        drain(60);
        check("tg_count", handshakes, 40);

        // ---- random traffic against the scoreboard ----
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 99) < 60, W'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 55, 0, 0);
        end
        drain(2000);
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
